// File: rtl/fgen_pkg.sv
// ============================================================================
// Module  : fgen_pkg
// Brief   : Shared types and step constants for the encoder parameter control.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fgen_pkg;

    typedef enum logic [1:0] {
        FLD_FREQ = 2'd0,
        FLD_AMP  = 2'd1,
        FLD_WAVE = 2'd2
    } field_e;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_HELD = 2'd1,
        PS_LONG = 2'd2
    } press_state_e;

    localparam int unsigned FREQ_STEP_FINE   = 1;
    localparam int unsigned FREQ_STEP_COARSE = 256;
    localparam int unsigned AMP_STEP_FINE    = 1;
    localparam int unsigned AMP_STEP_COARSE  = 16;
    localparam int unsigned ACCEL_MUL        = 4;

    function automatic field_e next_field(input field_e f);
        case (f)
            FLD_FREQ: next_field = FLD_AMP;
            FLD_AMP:  next_field = FLD_WAVE;
            default:  next_field = FLD_FREQ;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/press_classifier.sv
// ============================================================================
// Module  : press_classifier
// Brief   : Classifies push-switch holds into short and long press pulses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module press_classifier
    import fgen_pkg::*;
#(
    parameter logic [23:0] LONG_CYC = 24'd5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enc_s,
    output logic short_press,
    output logic long_press
);

    press_state_e state_q, state_d;
    logic [23:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PS_IDLE;
            cnt_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulses are combinational so a release lands in the same cycle as a detent.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        short_press = 1'b0;
        long_press  = 1'b0;
        case (state_q)
            PS_IDLE: begin
                cnt_d = 24'd0;
                if (enc_s) state_d = PS_HELD;
            end
            PS_HELD: begin
                if (!enc_s) begin
                    state_d     = PS_IDLE;
                    cnt_d       = 24'd0;
                    short_press = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                    if (cnt_d >= LONG_CYC) begin
                        state_d    = PS_LONG;
                        long_press = 1'b1;
                    end
                end
            end
            PS_LONG: begin
                if (!enc_s) begin
                    state_d = PS_IDLE;
                    cnt_d   = 24'd0;
                end
            end
            default: begin
                state_d = PS_IDLE;
                cnt_d   = 24'd0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/enc_param_ctrl.sv
// ============================================================================
// Module  : enc_param_ctrl
// Brief   : Rotary-encoder editor for frequency/amplitude/waveform settings.
//           Define ENC_PARAM_ACCEL_EN for fast-spin step acceleration.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module enc_param_ctrl
    import fgen_pkg::*;
#(
    parameter int          FREQ_W    = 16,
    parameter int          AMP_W     = 8,
    parameter logic [FREQ_W-1:0] FREQ_RST = 16'd256,
    parameter logic [23:0] LONG_CYC  = 24'd5_000_000,
    parameter logic [19:0] ACCEL_WIN = 20'd500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_p,
    input  logic              enc_d,
    input  logic              enc_s,
    output logic [FREQ_W-1:0] freq,
    output logic [AMP_W-1:0]  amp,
    output logic [1:0]        wave,
    output logic [1:0]        field,
    output logic              coarse,
    output logic              upd
);

    localparam logic [FREQ_W-1:0] C_F_MAX = '1;
    localparam logic [FREQ_W-1:0] C_F_MIN = {{(FREQ_W-1){1'b0}}, 1'b1};
    localparam logic [AMP_W-1:0]  C_A_MAX = '1;
    localparam logic [AMP_W-1:0]  C_A_RST = {1'b1, {(AMP_W-1){1'b0}}};

    logic              enc_p_q, enc_p_d;
    logic              block_q, block_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [AMP_W-1:0]  amp_q, amp_d;
    wave_e             wave_q, wave_d;
    field_e            field_q, field_d;
    logic              coarse_q, coarse_d;
    logic              upd_q, upd_d;
    logic              detent, accel, short_press, long_press;
    logic [31:0]       step_f, step_a;

    press_classifier #(.LONG_CYC(LONG_CYC)) u_press (
        .clk         (clk),
        .rst         (rst),
        .enc_s       (enc_s),
        .short_press (short_press),
        .long_press  (long_press)
    );

    // block_q masks a pulse already high when reset releases until it drops.
    assign detent  = enc_p & ~enc_p_q & ~block_q;
    assign enc_p_d = enc_p;
    assign block_d = block_q & enc_p;

`ifdef ENC_PARAM_ACCEL_EN
    logic [19:0] gap_q, gap_d;
    logic        last_dir_q, last_dir_d, have_prev_q, have_prev_d;

    always_comb begin
        gap_d       = gap_q;
        last_dir_d  = last_dir_q;
        have_prev_d = have_prev_q;
        accel       = detent & have_prev_q & (enc_d == last_dir_q) & (gap_q < ACCEL_WIN);
        if (detent) begin
            gap_d       = 20'd1;
            last_dir_d  = enc_d;
            have_prev_d = 1'b1;
        end else if (gap_q < ACCEL_WIN) begin
            gap_d = gap_q + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_q       <= 20'd0;
            last_dir_q  <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            gap_q       <= gap_d;
            last_dir_q  <= last_dir_d;
            have_prev_q <= have_prev_d;
        end
    end
`else
    assign accel = 1'b0;
`endif

    always_comb begin
        freq_d   = freq_q;
        amp_d    = amp_q;
        wave_d   = wave_q;
        field_d  = field_q;
        coarse_d = coarse_q;
        step_f   = coarse_q ? FREQ_STEP_COARSE : FREQ_STEP_FINE;
        step_a   = coarse_q ? AMP_STEP_COARSE  : AMP_STEP_FINE;
        if (accel) begin
            step_f = step_f * ACCEL_MUL;
            step_a = step_a * ACCEL_MUL;
        end
        // Saturation is decided on headroom so the arithmetic never wraps.
        if (detent) begin
            case (field_q)
                FLD_FREQ: begin
                    if (enc_d)
                        freq_d = (32'(C_F_MAX - freq_q) < step_f) ? C_F_MAX
                                                                  : freq_q + step_f[FREQ_W-1:0];
                    else
                        freq_d = (32'(freq_q) <= step_f) ? C_F_MIN
                                                         : freq_q - step_f[FREQ_W-1:0];
                end
                FLD_AMP: begin
                    if (enc_d)
                        amp_d = (32'(C_A_MAX - amp_q) < step_a) ? C_A_MAX
                                                                : amp_q + step_a[AMP_W-1:0];
                    else
                        amp_d = (32'(amp_q) < step_a) ? '0 : amp_q - step_a[AMP_W-1:0];
                end
                FLD_WAVE: wave_d = enc_d ? wave_e'(wave_q + 2'd1) : wave_e'(wave_q - 2'd1);
                default: ;
            endcase
        end
        if (short_press) field_d  = next_field(field_q);
        if (long_press)  coarse_d = ~coarse_q;
        upd_d = (freq_d != freq_q) | (amp_d != amp_q) | (wave_d != wave_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_p_q  <= 1'b0;
            block_q  <= 1'b1;
            freq_q   <= FREQ_RST;
            amp_q    <= C_A_RST;
            wave_q   <= WAVE_SINE;
            field_q  <= FLD_FREQ;
            coarse_q <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            enc_p_q  <= enc_p_d;
            block_q  <= block_d;
            freq_q   <= freq_d;
            amp_q    <= amp_d;
            wave_q   <= wave_d;
            field_q  <= field_d;
            coarse_q <= coarse_d;
            upd_q    <= upd_d;
        end
    end

    assign freq   = freq_q;
    assign amp    = amp_q;
    assign wave   = wave_q;
    assign field  = field_q;
    assign coarse = coarse_q;
    assign upd    = upd_q;

endmodule

`default_nettype wire

// File: tb/tb_enc_param_ctrl.sv
// ============================================================================
// Module  : tb_enc_param_ctrl
// Brief   : Scoreboard testbench for enc_param_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_enc_param_ctrl;

    localparam logic [23:0] C_LONG_CYC  = 24'd2000;
    localparam int          C_ACCEL_WIN = 500000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enc_p = 1'b0;
    logic        enc_d = 1'b0;
    logic        enc_s = 1'b0;
    logic [15:0] freq;
    logic [7:0]  amp;
    logic [1:0]  wave;
    logic [1:0]  field;
    logic        coarse;
    logic        upd;

    enc_param_ctrl #(
        .FREQ_W    (16),
        .AMP_W     (8),
        .FREQ_RST  (16'd256),
        .LONG_CYC  (C_LONG_CYC),
        .ACCEL_WIN (20'd500_000)
    ) dut (
        .clk    (clk),
        .rst    (rst_n),
        .enc_p  (enc_p),
        .enc_d  (enc_d),
        .enc_s  (enc_s),
        .freq   (freq),
        .amp    (amp),
        .wave   (wave),
        .field  (field),
        .coarse (coarse),
        .upd    (upd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int f;
        int a;
        int w;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    int m_freq = 256, m_amp = 128, m_wave = 0, m_field = 0;
    bit m_coarse = 1'b0;
    bit have_prev = 1'b0, last_dir = 1'b0;
    int last_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference behaviour of one detent, sampled at the coming rising edge.
    task automatic model_detent(input bit dir, output bit changed);
        int  step;
        int  v;
        bit  acc;
        acc = 1'b0;
`ifdef ENC_PARAM_ACCEL_EN
        acc = have_prev && (dir == last_dir) && ((cyc + 1 - last_cyc) < C_ACCEL_WIN);
`endif
        have_prev = 1'b1;
        last_dir  = dir;
        last_cyc  = cyc + 1;
        changed   = 1'b0;
        case (m_field)
            0: begin
                step = m_coarse ? 256 : 1;
                if (acc) step = step * 4;
                v = dir ? m_freq + step : m_freq - step;
                if (v > 65535) v = 65535;
                if (v < 1) v = 1;
                changed = (v != m_freq);
                m_freq  = v;
            end
            1: begin
                step = m_coarse ? 16 : 1;
                if (acc) step = step * 4;
                v = dir ? m_amp + step : m_amp - step;
                if (v > 255) v = 255;
                if (v < 0) v = 0;
                changed = (v != m_amp);
                m_amp   = v;
            end
            default: begin
                m_wave  = (m_wave + (dir ? 1 : 3)) % 4;
                changed = 1'b1;
            end
        endcase
        if (changed) sb.push_back('{m_freq, m_amp, m_wave});
    endtask

    task automatic detent(input bit dir, input int hi, input int gap);
        bit ch;
        enc_d = dir;
        enc_p = 1'b1;
        model_detent(dir, ch);
        @(posedge clk);
        #1;
        chk("upd_at_update", upd, ch);
        chk("freq_now", freq, m_freq);
        chk("amp_now", amp, m_amp);
        chk("wave_now", wave, m_wave);
        tick(hi);
        enc_p = 1'b0;
        tick(gap - hi);
    endtask

    task automatic press(input int n);
        bit is_long;
        is_long = (n - 1) >= int'(C_LONG_CYC);
        enc_s = 1'b1;
        tick(n);
        if (is_long) begin
            m_coarse = ~m_coarse;
            chk("coarse_held", coarse, m_coarse);
        end
        enc_s = 1'b0;
        if (!is_long) m_field = (m_field + 1) % 3;
        tick(3);
        chk("field", field, m_field);
        chk("coarse", coarse, m_coarse);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && upd) begin
            if (sb.size() == 0) begin
                chk("upd_spurious", upd, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_freq", freq, e.f);
                chk("sb_amp", amp, e.a);
                chk("sb_wave", wave, e.w);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_acc;
        bit ch;
        // Reset with the pulse already high: it must not count afterwards.
        rst_n = 1'b0; enc_p = 1'b1; enc_d = 1'b1;
        tick(3);
        chk("rst_freq", freq, 256);
        chk("rst_amp", amp, 128);
        chk("rst_wave", wave, 0);
        chk("rst_field", field, 0);
        chk("rst_coarse", coarse, 0);
        chk("rst_upd", upd, 0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        tick(5);
        chk("no_detent_after_rst", freq, 256);
        enc_p = 1'b0;
        tick(3);

        detent(1'b1, 256, 1000);
        chk("first_inc", freq, 257);
        detent(1'b1, 20, 40);
`ifdef ENC_PARAM_ACCEL_EN
        exp_acc = 261;
`else
        exp_acc = 258;
`endif
        chk("accel_freq", freq, exp_acc);

        press(1000);
        press(1000);
        press(1000);
        chk("three_presses", field, 0);

        press(1000);
        press(int'(C_LONG_CYC) + 10);
        chk("long_keeps_field", field, 1);
        detent(1'b0, 20, 40);
        chk("amp_coarse_dec", amp, 112);
        repeat (12) detent(1'b1, 5, 20);
        chk("amp_top", amp, 255);
        repeat (20) detent(1'b0, 5, 20);
        chk("amp_bottom", amp, 0);

        press(1000);
        repeat (3) detent(1'b1, 5, 20);
        chk("wave_3", wave, 3);
        detent(1'b1, 5, 20);
        chk("wave_wrap_up", wave, 0);
        detent(1'b0, 5, 20);
        chk("wave_wrap_dn", wave, 3);

        press(1000);
        repeat (4) detent(1'b0, 5, 20);
        chk("freq_floor", freq, 1);
        detent(1'b0, 5, 20);
        chk("freq_floor_hold", freq, 1);
        repeat (260) detent(1'b1, 4, 12);
        chk("freq_ceiling", freq, 65535);

        // Release and detent rise in the same cycle at AMP.
        press(1000);
        enc_s = 1'b1;
        tick(1000);
        enc_s = 1'b0;
        enc_d = 1'b1;
        enc_p = 1'b1;
        model_detent(1'b1, ch);
        m_field = 2;
        @(posedge clk);
        #1;
        chk("same_cycle_upd", upd, ch);
        chk("same_cycle_amp", amp, m_amp);
        tick(3);
        chk("same_cycle_field", field, 2);
        enc_p = 1'b0;
        tick(5);

        // Reset mid-hold and mid-detent discards both.
        enc_s = 1'b1;
        tick(100);
        enc_p = 1'b1;
        rst_n = 1'b0;
        tick(2);
        enc_s = 1'b0;
        m_freq = 256; m_amp = 128; m_wave = 0; m_field = 0; m_coarse = 1'b0;
        have_prev = 1'b0;
        chk("rst2_field", field, 0);
        chk("rst2_coarse", coarse, 0);
        rst_n = 1'b1;
        tick(10);
        chk("rst2_no_detent", freq, 256);
        chk("rst2_field_after", field, 0);
        enc_p = 1'b0;
        tick(3);
        detent(1'b0, 5, 20);
        chk("post_rst_dec", freq, 255);

        tick(5);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
